// File: rtl/fb_scanout.sv
// fb_scanout: raster-order reader for a 1-bit-per-pixel VGA framebuffer.
// Issues one read per visible pixel and realigns the returned data with the syncs.
module fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic        fb_rd_en,
    output logic [18:0] fb_rd_addr,
    input  logic        fb_rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pixel_out,
    output logic        vblank,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0] ADDR_MAX = 19'(H_ACTIVE * V_ACTIVE - 1);

    // One entry per issued cycle; tag marks a pix_en cycle whose result must reach the outputs.
    typedef struct packed {
        logic tag;
        logic hs;
        logic vs;
        logic act;
    } stage_t;

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [18:0] addr_cnt_q, addr_cnt_d;
    stage_t [RD_LAT-1:0] pipe_q, pipe_d;
    stage_t      out_stage;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_on_q, video_on_d;
    logic        pixel_out_q, pixel_out_d;
    logic        vblank_q, vblank_d;
    logic        frame_start_q, frame_start_d;
    logic        active;
    logic        at_origin;
    logic        hs_raw;
    logic        vs_raw;

    always_comb begin
        active     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        at_origin  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        hs_raw     = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        vs_raw     = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        fb_rd_en   = pix_en && active && !rst;
        // addr_cnt holds the next address; the origin pixel is forced to 0 while it reloads.
        fb_rd_addr = at_origin ? 19'd0 : addr_cnt_q;

        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        addr_cnt_d = addr_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            if (at_origin) begin
                addr_cnt_d = 19'd1;
            end else if (active && (addr_cnt_q != ADDR_MAX)) begin
                addr_cnt_d = addr_cnt_q + 19'd1;
            end
        end

        pipe_d[0] = '{tag: pix_en, hs: hs_raw, vs: vs_raw, act: active};
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        out_stage = pipe_q[RD_LAT-1];

        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        video_on_d  = video_on_q;
        pixel_out_d = pixel_out_q;
        // fb_rd_data belongs to the stage at the pipe's end in this same cycle.
        if (out_stage.tag) begin
            hsync_d     = out_stage.hs;
            vsync_d     = out_stage.vs;
            video_on_d  = out_stage.act;
            pixel_out_d = out_stage.act & fb_rd_data;
        end
        vblank_d      = (v_cnt_q >= V_ACT);
        frame_start_d = pix_en && at_origin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            addr_cnt_q    <= 19'd0;
            pipe_q        <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_out_q   <= 1'b0;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            addr_cnt_q    <= addr_cnt_d;
            pipe_q        <= pipe_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_out_q   <= pixel_out_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_out   = pixel_out_q;
    assign vblank      = vblank_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: full-size instance (RD_LAT=1) for line/hsync timing,
// reduced 15x8 instance (RD_LAT=3) for whole frames, mid-frame reset and gappy strobes.
module tb_fb_scanout;
  localparam int HA  [2] = '{640, 8};
  localparam int HFP [2] = '{16, 2};
  localparam int HS  [2] = '{96, 3};
  localparam int HBP [2] = '{48, 2};
  localparam int VA  [2] = '{480, 4};
  localparam int VFP [2] = '{10, 1};
  localparam int VS  [2] = '{2, 2};
  localparam int VBP [2] = '{33, 1};
  localparam int LAT [2] = '{1, 3};

  typedef struct {
    bit tag;
    bit hs;
    bit vs;
    bit act;
    int addr;
  } stage_t;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, pix_en_a = 1'b0, fb_rd_data_a;
  logic        fb_rd_en_a, hsync_a, vsync_a, video_on_a, pixel_out_a, vblank_a, frame_start_a;
  logic [18:0] fb_rd_addr_a;
  logic        rst_b = 1'b1, pix_en_b = 1'b0, fb_rd_data_b;
  logic        fb_rd_en_b, hsync_b, vsync_b, video_on_b, pixel_out_b, vblank_b, frame_start_b;
  logic [18:0] fb_rd_addr_b;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus requested for the next cycle, and what was actually applied this cycle
  bit nx_pe [2] = '{0, 0};
  bit nx_rst[2] = '{1, 1};
  bit ap_pe [2] = '{0, 0};
  bit ap_rst[2] = '{1, 1};
  bit force1 = 1'b0;

  // reference model state
  int     mh[2] = '{0, 0};
  int     mv[2] = '{0, 0};
  stage_t hist[2][4];
  bit e_hs[2], e_vs[2], e_von[2], e_pix[2], e_vb[2], e_fs[2];
  bit exp_en[2];
  int exp_addr[2];

  fb_scanout dut_a (
    .clk(clk), .rst(rst_a), .pix_en(pix_en_a),
    .fb_rd_en(fb_rd_en_a), .fb_rd_addr(fb_rd_addr_a), .fb_rd_data(fb_rd_data_a),
    .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a), .pixel_out(pixel_out_a),
    .vblank(vblank_a), .frame_start(frame_start_a)
  );

  fb_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LAT(3)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pix_en(pix_en_b),
    .fb_rd_en(fb_rd_en_b), .fb_rd_addr(fb_rd_addr_b), .fb_rd_data(fb_rd_data_b),
    .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b), .pixel_out(pixel_out_b),
    .vblank(vblank_b), .frame_start(frame_start_b)
  );

  // ---------------- clock / memories ----------------
  initial forever #5 clk = ~clk;

  function automatic bit mem_a(input int a, input bit f);
    return f ? 1'b1 : a[0];
  endfunction

  function automatic bit mem_b(input int a);
    return a[0] ^ a[2];
  endfunction

  logic [18:0] mp_a[1];
  logic [18:0] mp_b[3];
  always @(posedge clk) begin
    mp_a[0] <= fb_rd_addr_a;
    mp_b[0] <= fb_rd_addr_b;
    mp_b[1] <= mp_b[0];
    mp_b[2] <= mp_b[1];
  end
  assign fb_rd_data_a = mem_a(int'(mp_a[0]), force1);
  assign fb_rd_data_b = mem_b(int'(mp_b[2]));

  // ---------------- reference model ----------------
  task automatic advance(input int i);
    stage_t o;
    int ht, vt;
    ht = HA[i] + HFP[i] + HS[i] + HBP[i];
    vt = VA[i] + VFP[i] + VS[i] + VBP[i];
    if (ap_rst[i]) begin
      mh[i] = 0;
      mv[i] = 0;
      for (int j = 0; j < 4; j++) hist[i][j] = '{0, 0, 0, 0, 0};
      e_hs[i] = 1; e_vs[i] = 1; e_von[i] = 0; e_pix[i] = 0; e_vb[i] = 0; e_fs[i] = 0;
    end else begin
      o = hist[i][LAT[i]-1];
      if (o.tag) begin
        e_hs[i]  = o.hs;
        e_vs[i]  = o.vs;
        e_von[i] = o.act;
        e_pix[i] = o.act ? ((i == 0) ? mem_a(o.addr, force1) : mem_b(o.addr)) : 1'b0;
      end
      for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0].tag  = ap_pe[i];
      hist[i][0].hs   = !(mh[i] >= HA[i] + HFP[i] && mh[i] < HA[i] + HFP[i] + HS[i]);
      hist[i][0].vs   = !(mv[i] >= VA[i] + VFP[i] && mv[i] < VA[i] + VFP[i] + VS[i]);
      hist[i][0].act  = (mh[i] < HA[i]) && (mv[i] < VA[i]);
      hist[i][0].addr = mv[i] * HA[i] + mh[i];
      e_vb[i] = (mv[i] >= VA[i]);
      e_fs[i] = ap_pe[i] && mh[i] == 0 && mv[i] == 0;
      if (ap_pe[i]) begin
        if (mh[i] == ht - 1) begin
          mh[i] = 0;
          mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
        end else begin
          mh[i] = mh[i] + 1;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: apply the edge to the model, drive inputs at negedge, observe 1 ns later.
  task automatic tick();
    advance(0);
    advance(1);
    @(negedge clk);
    rst_a = nx_rst[0]; pix_en_a = nx_pe[0];
    rst_b = nx_rst[1]; pix_en_b = nx_pe[1];
    ap_rst = nx_rst;
    ap_pe  = nx_pe;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_en[i]   = !ap_rst[i] && ap_pe[i] && (mh[i] < HA[i]) && (mv[i] < VA[i]);
      exp_addr[i] = mv[i] * HA[i] + mh[i];
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nx_rst[0] = 1; nx_pe[0] = 1;
    repeat (3) begin
      tick();
      n_checks++; if (fb_rd_en_a !== 1'b0) begin n_errors++; $display("FAIL reset_rd_en: got %b, expected 0", fb_rd_en_a); end
      n_checks++; if (hsync_a !== 1'b1) begin n_errors++; $display("FAIL reset_hsync: got %b, expected 1", hsync_a); end
      n_checks++; if (vsync_a !== 1'b1) begin n_errors++; $display("FAIL reset_vsync: got %b, expected 1", vsync_a); end
      n_checks++; if (video_on_a !== 1'b0) begin n_errors++; $display("FAIL reset_video_on: got %b, expected 0", video_on_a); end
      n_checks++; if (pixel_out_a !== 1'b0) begin n_errors++; $display("FAIL reset_pixel_out: got %b, expected 0", pixel_out_a); end
      n_checks++; if (vblank_a !== 1'b0) begin n_errors++; $display("FAIL reset_vblank: got %b, expected 0", vblank_a); end
      n_checks++; if (frame_start_a !== 1'b0) begin n_errors++; $display("FAIL reset_frame_start: got %b, expected 0", frame_start_a); end
    end
    nx_rst[0] = 0;
    tick();
    n_checks++; if (fb_rd_en_a !== 1'b1) begin n_errors++; $display("FAIL first_rd_en: got %b, expected 1", fb_rd_en_a); end
    n_checks++; if (fb_rd_addr_a !== 19'd0) begin n_errors++; $display("FAIL first_addr: got %0d, expected 0", fb_rd_addr_a); end
    n_checks++; if (frame_start_a !== 1'b0) begin n_errors++; $display("FAIL first_fs_early: got %b, expected 0", frame_start_a); end
    tick();
    n_checks++; if (frame_start_a !== 1'b1) begin n_errors++; $display("FAIL first_frame_start: got %b, expected 1", frame_start_a); end
    n_checks++; if (fb_rd_addr_a !== 19'd1) begin n_errors++; $display("FAIL second_addr: got %0d, expected 1", fb_rd_addr_a); end
  endtask

  task automatic test_line0();
    int von_cnt = 0;
    bit exp_von, exp_pix;
    for (int t = 0; t < 700; t++) begin
      tick();
      if (mh[0] < 640) begin
        n_checks++; if (fb_rd_en_a !== 1'b1) begin n_errors++; $display("FAIL line0_rd_en x=%0d: got %b, expected 1", mh[0], fb_rd_en_a); end
        n_checks++; if (fb_rd_addr_a !== 19'(mh[0])) begin n_errors++; $display("FAIL line0_addr: got %0d, expected %0d", fb_rd_addr_a, mh[0]); end
      end else begin
        n_checks++; if (fb_rd_en_a !== 1'b0) begin n_errors++; $display("FAIL line0_rd_en_blank h=%0d: got %b, expected 0", mh[0], fb_rd_en_a); end
      end
      exp_von = (mh[0] >= 2 && mh[0] < 642);
      exp_pix = exp_von && ((mh[0] - 2) % 2 == 1);
      n_checks++; if (video_on_a !== exp_von) begin n_errors++; $display("FAIL line0_video_on h=%0d: got %b, expected %b", mh[0], video_on_a, exp_von); end
      n_checks++; if (pixel_out_a !== exp_pix) begin n_errors++; $display("FAIL line0_pixel h=%0d: got %b, expected %b", mh[0], pixel_out_a, exp_pix); end
      n_checks++; if (frame_start_a !== 1'b0) begin n_errors++; $display("FAIL line0_frame_start h=%0d: got %b, expected 0", mh[0], frame_start_a); end
      if (video_on_a === 1'b1) von_cnt++;
      if (mh[0] == 650) break;
    end
    n_checks++; if (mh[0] != 650) begin n_errors++; $display("FAIL line0_timeout: got h=%0d, expected 650", mh[0]); end
    n_checks++; if (von_cnt != 640) begin n_errors++; $display("FAIL line0_video_on_count: got %0d, expected 640", von_cnt); end
  endtask

  task automatic test_hsync();
    int low_cnt = 0;
    int first_low = -1;
    bit exp_hs, exp_pix;
    force1 = 1;
    for (int t = 0; t < 800; t++) begin
      tick();
      exp_hs  = !(mh[0] >= 658 && mh[0] < 754);
      exp_pix = (mv[0] == 1) && (mh[0] >= 2 && mh[0] < 642);
      n_checks++; if (hsync_a !== exp_hs) begin n_errors++; $display("FAIL hsync v=%0d h=%0d: got %b, expected %b", mv[0], mh[0], hsync_a, exp_hs); end
      n_checks++; if (pixel_out_a !== exp_pix) begin n_errors++; $display("FAIL hsync_pixel v=%0d h=%0d: got %b, expected %b", mv[0], mh[0], pixel_out_a, exp_pix); end
      n_checks++; if (vsync_a !== 1'b1) begin n_errors++; $display("FAIL hsync_vsync: got %b, expected 1", vsync_a); end
      if (hsync_a === 1'b0) begin
        if (first_low < 0) first_low = mh[0];
        low_cnt++;
        n_checks++; if (pixel_out_a !== 1'b0) begin n_errors++; $display("FAIL hsync_pixel_forced h=%0d: got %b, expected 0", mh[0], pixel_out_a); end
      end
    end
    force1 = 0;
    n_checks++; if (low_cnt != 96) begin n_errors++; $display("FAIL hsync_width: got %0d, expected 96", low_cnt); end
    n_checks++; if (first_low != 658) begin n_errors++; $display("FAIL hsync_start: got %0d, expected 658", first_low); end
    nx_pe[0] = 0;
  endtask

  task automatic test_full_frame();
    int reads = 0, last_addr = -1, vs_low = 0, vb_high = 0, fs_cnt = 0, f2_addr = -1;
    nx_rst[1] = 0;
    for (int t = 0; t < 480; t++) begin
      nx_pe[1] = (t % 2 == 0);
      tick();
      n_checks++; if (fb_rd_en_b !== exp_en[1]) begin n_errors++; $display("FAIL ff_rd_en t=%0d: got %b, expected %b", t, fb_rd_en_b, exp_en[1]); end
      if (exp_en[1]) begin
        n_checks++; if (fb_rd_addr_b !== 19'(exp_addr[1])) begin n_errors++; $display("FAIL ff_addr t=%0d: got %0d, expected %0d", t, fb_rd_addr_b, exp_addr[1]); end
      end
      n_checks++; if (hsync_b !== e_hs[1]) begin n_errors++; $display("FAIL ff_hsync t=%0d: got %b, expected %b", t, hsync_b, e_hs[1]); end
      n_checks++; if (vsync_b !== e_vs[1]) begin n_errors++; $display("FAIL ff_vsync t=%0d: got %b, expected %b", t, vsync_b, e_vs[1]); end
      n_checks++; if (video_on_b !== e_von[1]) begin n_errors++; $display("FAIL ff_video_on t=%0d: got %b, expected %b", t, video_on_b, e_von[1]); end
      n_checks++; if (pixel_out_b !== e_pix[1]) begin n_errors++; $display("FAIL ff_pixel t=%0d: got %b, expected %b", t, pixel_out_b, e_pix[1]); end
      n_checks++; if (vblank_b !== e_vb[1]) begin n_errors++; $display("FAIL ff_vblank t=%0d: got %b, expected %b", t, vblank_b, e_vb[1]); end
      n_checks++; if (frame_start_b !== e_fs[1]) begin n_errors++; $display("FAIL ff_frame_start t=%0d: got %b, expected %b", t, frame_start_b, e_fs[1]); end
      if (t < 240 && fb_rd_en_b === 1'b1) begin reads++; last_addr = int'(fb_rd_addr_b); end
      if (t >= 240 && f2_addr < 0 && fb_rd_en_b === 1'b1) f2_addr = int'(fb_rd_addr_b);
      if (t < 248 && vsync_b === 1'b0) vs_low++;
      if (t < 248 && vblank_b === 1'b1) vb_high++;
      if (frame_start_b === 1'b1) fs_cnt++;
    end
    n_checks++; if (reads != 32) begin n_errors++; $display("FAIL ff_reads: got %0d, expected 32", reads); end
    n_checks++; if (last_addr != 31) begin n_errors++; $display("FAIL ff_last_addr: got %0d, expected 31", last_addr); end
    n_checks++; if (vs_low != 60) begin n_errors++; $display("FAIL ff_vsync_cycles: got %0d, expected 60", vs_low); end
    n_checks++; if (vb_high != 120) begin n_errors++; $display("FAIL ff_vblank_cycles: got %0d, expected 120", vb_high); end
    n_checks++; if (fs_cnt != 2) begin n_errors++; $display("FAIL ff_frame_start_count: got %0d, expected 2", fs_cnt); end
    n_checks++; if (f2_addr != 0) begin n_errors++; $display("FAIL ff_frame2_addr: got %0d, expected 0", f2_addr); end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    nx_pe[1] = 1;
    for (int t = 0; t < 300; t++) begin
      tick();
      if (mv[1] == 2 && mh[1] == 5) begin found = 1; break; end
    end
    n_checks++; if (!found) begin n_errors++; $display("FAIL mid_reach: got 0, expected 1"); end
    nx_rst[1] = 1;
    tick();
    nx_rst[1] = 0;
    tick();
    n_checks++; if (fb_rd_en_b !== 1'b1) begin n_errors++; $display("FAIL mid_rd_en: got %b, expected 1", fb_rd_en_b); end
    n_checks++; if (fb_rd_addr_b !== 19'd0) begin n_errors++; $display("FAIL mid_addr: got %0d, expected 0", fb_rd_addr_b); end
    n_checks++; if (hsync_b !== 1'b1 || vsync_b !== 1'b1) begin n_errors++; $display("FAIL mid_syncs: got %b%b, expected 11", hsync_b, vsync_b); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      n_checks++; if (video_on_b !== 1'b0) begin n_errors++; $display("FAIL mid_stale_video_on k=%0d: got %b, expected 0", k, video_on_b); end
      n_checks++; if (pixel_out_b !== 1'b0) begin n_errors++; $display("FAIL mid_stale_pixel k=%0d: got %b, expected 0", k, pixel_out_b); end
      n_checks++; if (frame_start_b !== (k == 1)) begin n_errors++; $display("FAIL mid_frame_start k=%0d: got %b, expected %b", k, frame_start_b, k == 1); end
    end
    tick();
    n_checks++; if (video_on_b !== 1'b1) begin n_errors++; $display("FAIL mid_first_video_on: got %b, expected 1", video_on_b); end
  endtask

  task automatic test_irregular();
    int nxt = -1;
    for (int t = 0; t < 400; t++) begin
      nx_pe[1] = ($urandom_range(0, 1) == 1);
      tick();
      n_checks++; if (fb_rd_en_b !== exp_en[1]) begin n_errors++; $display("FAIL irr_rd_en t=%0d: got %b, expected %b", t, fb_rd_en_b, exp_en[1]); end
      if (exp_en[1]) begin
        if (nxt < 0) nxt = exp_addr[1];
        n_checks++; if (fb_rd_addr_b !== 19'(nxt)) begin n_errors++; $display("FAIL irr_addr t=%0d: got %0d, expected %0d", t, fb_rd_addr_b, nxt); end
        nxt = (nxt + 1) % 32;
      end
      n_checks++; if (pixel_out_b !== e_pix[1]) begin n_errors++; $display("FAIL irr_pixel t=%0d: got %b, expected %b", t, pixel_out_b, e_pix[1]); end
      n_checks++; if (video_on_b !== e_von[1]) begin n_errors++; $display("FAIL irr_video_on t=%0d: got %b, expected %b", t, video_on_b, e_von[1]); end
      n_checks++; if (hsync_b !== e_hs[1] || vsync_b !== e_vs[1]) begin n_errors++; $display("FAIL irr_syncs t=%0d: got %b%b, expected %b%b", t, hsync_b, vsync_b, e_hs[1], e_vs[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_line0();
    test_hsync();
    test_full_frame();
    test_reset_mid();
    test_irregular();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
